// File: rtl/psram_pkg.sv
// Shared constants and types for the PSRAM transfer engine.
// PSRAM_OCTAL_EN selects an 8-lane bus; the default build is quad (4 lanes).
package psram_pkg;

  localparam logic [7:0] PSRAM_CMD_QWR = 8'h38;
  localparam logic [7:0] PSRAM_CMD_QRD = 8'hEB;

`ifdef PSRAM_OCTAL_EN
  localparam int LANES = 8;
`else
  localparam int LANES = 4;
`endif

  localparam int CMD_PERIODS  = 8 / LANES;
  localparam int DATA_PERIODS = 32 / LANES;
  localparam logic [7:0] LANE_MASK = 8'((1 << LANES) - 1);
  localparam logic [19:0] DIV_MIN = 20'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_DONE
  } state_e;

  // Address bits are rounded up to whole SCK periods; the extra bits go out as leading zeros.
  function automatic int addrPeriods(input int addrWidth);
    return (addrWidth + LANES - 1) / LANES;
  endfunction

  function automatic logic [19:0] clampDiv(input logic [19:0] pscr);
    return (pscr < DIV_MIN) ? DIV_MIN : pscr;
  endfunction

endpackage

// File: rtl/psram_clkgen.sv
// SCK generator: period div_i clk cycles, low for floor(div_i/2) cycles, then high.
// rise_o marks the first high cycle, fall_o the last cycle before the counter wraps.
module psram_clkgen (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        en_i,
  input  logic [19:0] div_i,
  output logic        sck_o,
  output logic        rise_o,
  output logic        fall_o
);

  logic [19:0] cnt_q, cnt_d;
  logic [19:0] half;

  assign half   = div_i >> 1;
  assign rise_o = en_i && (cnt_q == half);
  assign fall_o = en_i && (cnt_q == div_i - 20'd1);
  assign sck_o  = en_i && (cnt_q >= half);

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || fall_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 20'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/psram_xfer.sv
// PSRAM quad/octal SPI transfer engine moving one 32-bit word per request.
// Define PSRAM_OCTAL_EN for an 8-lane bus; the default build drives 4 lanes.
module psram_xfer #(
  parameter int ADDR_WIDTH = 24
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [19:0]           pscr_i,
  input  logic [4:0]            dummy_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [31:0]           rsp_rdata_o,
  output logic                  busy_o,
  output logic                  psram_sck_o,
  output logic                  psram_ce_o,
  output logic [7:0]            psram_io_en_o,
  output logic [7:0]            psram_io_out_o,
  input  logic [7:0]            psram_io_in_i
);

  import psram_pkg::*;

  localparam int ADDR_PERIODS = addrPeriods(ADDR_WIDTH);
  localparam int ADDR_BITS    = ADDR_PERIODS * LANES;
  localparam int SHIFT_W      = 8 + ADDR_BITS + 32;

  localparam logic [7:0] CMD_LAST  = 8'(CMD_PERIODS - 1);
  localparam logic [7:0] ADDR_LAST = 8'(ADDR_PERIODS - 1);
  localparam logic [7:0] DATA_LAST = 8'(DATA_PERIODS - 1);

  state_e             state_q, state_d;
  logic               we_q, we_d;
  logic [19:0]        div_q, div_d;
  logic [4:0]         dummy_q, dummy_d;
  logic [7:0]         perCnt_q, perCnt_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [31:0]        rdAcc_q, rdAcc_d;
  logic [31:0]        rspRdata_q, rspRdata_d;
  logic               rspValid_q, rspValid_d;

  logic clkEn, sckRaw, sckRise, sckFall;
  logic frameActive, driveLanes;
  logic unusedLanes;

  assign clkEn = (state_q != ST_IDLE);

  psram_clkgen u_clkgen (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .en_i   (clkEn),
    .div_i  (div_q),
    .sck_o  (sckRaw),
    .rise_o (sckRise),
    .fall_o (sckFall)
  );

  // Command, address and write word form one shift register emptied MSB first.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    div_d      = div_q;
    dummy_d    = dummy_q;
    perCnt_d   = perCnt_q;
    shift_d    = shift_q;
    rdAcc_d    = rdAcc_q;
    rspRdata_d = rspRdata_q;
    rspValid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          we_d     = req_we_i;
          div_d    = clampDiv(pscr_i);
          dummy_d  = dummy_i;
          perCnt_d = '0;
          rdAcc_d  = '0;
          shift_d  = {req_we_i ? PSRAM_CMD_QWR : PSRAM_CMD_QRD,
                      ADDR_BITS'(req_addr_i), req_wdata_i};
          state_d  = ST_CMD;
        end
      end

      ST_CMD: begin
        if (sckFall) begin
          shift_d = shift_q << LANES;
          if (perCnt_q == CMD_LAST) begin
            perCnt_d = '0;
            state_d  = ST_ADDR;
          end else begin
            perCnt_d = perCnt_q + 8'd1;
          end
        end
      end

      ST_ADDR: begin
        if (sckFall) begin
          shift_d = shift_q << LANES;
          if (perCnt_q == ADDR_LAST) begin
            perCnt_d = '0;
            state_d  = (!we_q && dummy_q != 5'd0) ? ST_DUMMY : ST_DATA;
          end else begin
            perCnt_d = perCnt_q + 8'd1;
          end
        end
      end

      ST_DUMMY: begin
        if (sckFall) begin
          if (perCnt_q == 8'(dummy_q) - 8'd1) begin
            perCnt_d = '0;
            state_d  = ST_DATA;
          end else begin
            perCnt_d = perCnt_q + 8'd1;
          end
        end
      end

      // With a divider of 2 the last sample and the wrap share a cycle, so rdAcc_d is forwarded.
      ST_DATA: begin
        if (sckRise && !we_q) begin
          rdAcc_d = {rdAcc_q[31-LANES:0], psram_io_in_i[LANES-1:0]};
        end
        if (sckFall) begin
          shift_d = shift_q << LANES;
          if (perCnt_q == DATA_LAST) begin
            perCnt_d   = '0;
            rspValid_d = 1'b1;
            rspRdata_d = we_q ? 32'h0 : rdAcc_d;
            state_d    = ST_DONE;
          end else begin
            perCnt_d = perCnt_q + 8'd1;
          end
        end
      end

      ST_DONE: begin
        if (sckFall) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      div_q      <= DIV_MIN;
      dummy_q    <= '0;
      perCnt_q   <= '0;
      shift_q    <= '0;
      rdAcc_q    <= '0;
      rspRdata_q <= '0;
      rspValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      div_q      <= div_d;
      dummy_q    <= dummy_d;
      perCnt_q   <= perCnt_d;
      shift_q    <= shift_d;
      rdAcc_q    <= rdAcc_d;
      rspRdata_q <= rspRdata_d;
      rspValid_q <= rspValid_d;
    end
  end

  // SCK is held low in DONE so CE-high time never carries clock edges.
  assign frameActive = state_q inside {ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA};
  assign driveLanes  = (state_q inside {ST_CMD, ST_ADDR}) || (state_q == ST_DATA && we_q);

  assign req_ready_o    = (state_q == ST_IDLE);
  assign busy_o         = (state_q != ST_IDLE);
  assign rsp_valid_o    = rspValid_q;
  assign rsp_rdata_o    = rspRdata_q;
  assign psram_sck_o    = sckRaw && frameActive;
  assign psram_ce_o     = !frameActive;
  assign psram_io_en_o  = driveLanes ? LANE_MASK : 8'h00;
  assign psram_io_out_o = driveLanes ? 8'(shift_q[SHIFT_W-1 -: LANES]) : 8'h00;

  assign unusedLanes = ^(psram_io_in_i & ~LANE_MASK);

endmodule

// File: tb/tb_psram_xfer.sv
`timescale 1ns/1ps
// Scoreboard bench for psram_xfer: directed requests push expected completions,
// a monitor pops them on rsp_valid_o and compares against the observed SPI frame.
module tb_psram_xfer;
  import psram_pkg::*;

  localparam int AW      = 24;
  localparam int CLK_NS  = 10;
  localparam int TIMEOUT = 5000;
  localparam logic [63:0] RESET_VEC = 64'({1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 32'h0});

  typedef struct {
    logic [31:0] rdata;
    logic [63:0] stream;
    int          enPeriods;
    int          rises;
    int          div;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic [19:0]   pscr = 20'd4;
  logic [4:0]    dummy = 5'd0;
  logic          reqValid = 1'b0;
  logic          reqWe = 1'b0;
  logic [AW-1:0] reqAddr = '0;
  logic [31:0]   reqWdata = '0;
  logic [7:0]    psramIoIn = 8'h00;
  logic          reqReady, rspValid, busy, psramSck, psramCe;
  logic [31:0]   rspRdata;
  logic [7:0]    psramIoEn, psramIoOut;

  always #5 clk = ~clk;

  psram_xfer #(.ADDR_WIDTH(AW)) dut (
    .clk_i         (clk),
    .rst_n_i       (rstN),
    .pscr_i        (pscr),
    .dummy_i       (dummy),
    .req_valid_i   (reqValid),
    .req_ready_o   (reqReady),
    .req_we_i      (reqWe),
    .req_addr_i    (reqAddr),
    .req_wdata_i   (reqWdata),
    .rsp_valid_o   (rspValid),
    .rsp_rdata_o   (rspRdata),
    .busy_o        (busy),
    .psram_sck_o   (psramSck),
    .psram_ce_o    (psramCe),
    .psram_io_en_o (psramIoEn),
    .psram_io_out_o(psramIoOut),
    .psram_io_in_i (psramIoIn)
  );

  exp_t expQ[$];
  int   checks = 0;
  int   passes = 0;
  int   rspCount = 0;

  logic [63:0] stream = '0;
  int          enPeriods = 0, rises = 0, minPer = 0, maxPer = 0;
  bit          badLane = 1'b0, haveRise = 1'b0, prevValid = 1'b0;
  time         lastRise = 0, ceRiseTime = 0, ceGap = 0;

  logic [31:0] modelWord = '0;
  int          modelDummy = 0;
  int          modelRises = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
  endtask

  function automatic logic [63:0] outVec();
    return 64'({reqReady, busy, psramCe, psramSck, rspValid, psramIoEn, psramIoOut, rspRdata});
  endfunction

  function automatic logic [7:0] laneValue(input logic [31:0] w, input int idx);
    logic [31:0] s;
    s = w << (idx * LANES);
    return (8'(s >> (32 - LANES)) & LANE_MASK) | (8'hA5 & ~LANE_MASK);
  endfunction

  // Frame observer: what the PSRAM would see on each SCK rising edge while CE is low.
  always @(negedge psramCe) begin
    stream = '0; enPeriods = 0; rises = 0; minPer = 1 << 30; maxPer = 0;
    badLane = 1'b0; haveRise = 1'b0;
    ceGap = $time - ceRiseTime;
  end

  always @(posedge psramCe) ceRiseTime = $time;

  always @(posedge psramSck) begin : frameMon
    int per;
    if (!psramCe) begin
      rises++;
      if (haveRise) begin
        per = int'(($time - lastRise) / CLK_NS);
        if (per < minPer) minPer = per;
        if (per > maxPer) maxPer = per;
      end
      haveRise = 1'b1;
      lastRise = $time;
      if (psramIoEn != 8'h00) begin
        if (psramIoEn != LANE_MASK) badLane = 1'b1;
        enPeriods++;
        stream = (stream << LANES) | 64'(psramIoOut & LANE_MASK);
      end
      if (((psramIoEn | psramIoOut) & ~LANE_MASK) != 8'h00) badLane = 1'b1;
    end
  end

  // Read model: presents the next data group after each SCK falling edge.
  always @(negedge psramCe) begin
    modelRises = 0;
    psramIoIn  = 8'h5A;
  end

  always @(posedge psramSck) modelRises++;

  always @(negedge psramSck) begin : readModel
    int idx;
    idx = modelRises - ((8 + AW) / LANES + modelDummy);
    if (idx >= 0 && idx < 32 / LANES) psramIoIn = laneValue(modelWord, idx);
    else psramIoIn = 8'h5A;
  end

  // Scoreboard monitor.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rspValid) begin
      rspCount++;
      if (expQ.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_rsp: rsp_valid_o actual 1 required 0");
      end else begin
        e = expQ.pop_front();
        checkOutput("rsp_pulse_start", 64'(prevValid), 64'd0);
        checkOutput("rsp_rdata", 64'(rspRdata), 64'(e.rdata));
        checkOutput("lane_stream", stream, e.stream);
        checkOutput("driven_periods", 64'(enPeriods), 64'(e.enPeriods));
        checkOutput("sck_periods_ce_low", 64'(rises), 64'(e.rises));
        checkOutput("sck_period_min", 64'(minPer), 64'(e.div));
        checkOutput("sck_period_max", 64'(maxPer), 64'(e.div));
        checkOutput("unused_lanes_quiet", 64'(badLane), 64'd0);
      end
    end
    prevValid = rspValid;
  end

  task automatic applyStimulus(input bit we, input logic [AW-1:0] addr, input logic [31:0] wdata,
                               input logic [19:0] pscrIn, input logic [4:0] dummyIn,
                               input logic [31:0] model, input bit hold);
    exp_t e;
    int   n;
    e.div       = (pscrIn < 20'd2) ? 2 : int'(pscrIn);
    e.rdata     = we ? 32'h0 : model;
    e.stream    = we ? {8'h38, addr, wdata} : {32'h0, 8'hEB, addr};
    e.enPeriods = (we ? 64 : 32) / LANES;
    e.rises     = (8 + AW) / LANES + (we ? 0 : int'(dummyIn)) + 32 / LANES;
    @(negedge clk);
    reqWe = we; reqAddr = addr; reqWdata = wdata; pscr = pscrIn; dummy = dummyIn;
    modelWord = model; modelDummy = int'(dummyIn);
    reqValid = 1'b1;
    n = 0;
    while (!reqReady && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    checkOutput("request_accepted", 64'(n < TIMEOUT), 64'd1);
    if (n >= TIMEOUT) begin
      reqValid = 1'b0;
      return;
    end
    @(posedge clk);
    expQ.push_back(e);
    #1;
    if (!hold) reqValid = 1'b0;
    reqWe = ~we; reqAddr = ~addr; reqWdata = ~wdata; pscr = 20'd9; dummy = ~dummyIn;
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while ((expQ.size() != 0 || !reqReady) && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    checkOutput("transfer_completed", 64'(n < TIMEOUT), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running at 1 ms, required finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : mainSeq
    int cntBefore;
    int n;
    #1;
    checkOutput("reset_outputs", outVec(), RESET_VEC);
    @(negedge clk);
    rstN = 1'b1;
    repeat (2) @(negedge clk);

    applyStimulus(1'b1, 24'h001234, 32'hDEADBEEF, 20'd4, 5'd0, 32'h0, 1'b0);
    checkOutput("busy_not_ready_in_transfer", 64'({busy, reqReady}), 64'(2'b10));
    waitDone();
    checkOutput("write_rdata_zero", 64'(rspRdata), 64'h0);

    applyStimulus(1'b0, 24'h000100, 32'h0, 20'd3, 5'd6, 32'hCAFEF00D, 1'b0);
    waitDone();
    repeat (5) @(negedge clk);
    checkOutput("read_rdata_held", 64'(rspRdata), 64'hCAFEF00D);

    applyStimulus(1'b1, 24'h0000AB, 32'h12345678, 20'd0, 5'd0, 32'h0, 1'b0);
    waitDone();
    applyStimulus(1'b1, 24'hFFFFFF, 32'h00000000, 20'd1, 5'd3, 32'h0, 1'b0);
    waitDone();

    applyStimulus(1'b1, 24'h000010, 32'hA5A5A5A5, 20'd5, 5'd0, 32'h0, 1'b1);
    cntBefore = rspCount;
    applyStimulus(1'b0, 24'h000020, 32'h0, 20'd5, 5'd0, 32'h13579BDF, 1'b0);
    checkOutput("b2b_first_done_before_accept", 64'(rspCount - cntBefore), 64'd1);
    checkOutput("b2b_ce_gap_ge_div", 64'(ceGap >= time'(5 * CLK_NS)), 64'd1);
    waitDone();

    applyStimulus(1'b0, 24'h000040, 32'h0, 20'd2, 5'd4, 32'h11112222, 1'b0);
    n = 0;
    while (rises < (8 + AW) / LANES + 4 + 2 && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    checkOutput("abort_reached_data", 64'(n < TIMEOUT), 64'd1);
    cntBefore = rspCount;
    #2 rstN = 1'b0;
    #1 checkOutput("abort_reset_outputs", outVec(), RESET_VEC);
    expQ.delete();
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("abort_no_rsp", 64'(rspCount - cntBefore), 64'd0);

    applyStimulus(1'b0, 24'h000055, 32'h0, 20'd2, 5'd2, 32'h0F1E2D3C, 1'b0);
    waitDone();
    applyStimulus(1'b1, 24'hABCDEF, 32'h01020304, 20'd4, 5'd0, 32'h0, 1'b0);
    waitDone();

    repeat (5) @(negedge clk);
    checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
